// File: rtl/spi_stream_tx.sv
// spi_stream_tx
//   Multi-channel serial pattern transmitter. Each channel repeatedly sends a
//   self-incrementing WIDTH-bit word, MSB first, on its own CS/SCLK/SDO
//   lines while its enable is high. One shared clock divider produces the
//   SCLK half-period tick, so every channel stays tick-aligned.
//
// Ports
//   CLK_IN      system clock
//   RST_N       asynchronous active-low reset
//   enable      per-channel run request (sampled only on ticks in IDLE and
//               at the end of the inter-frame gap)
//   CS          per-channel chip select, active low
//   SCLK        per-channel serial clock, idles at CPOL
//   SDO         per-channel serial data, MSB first, changes on trailing edge
//   busy        high while the channel FSM is not in IDLE
//   frame_done  one-cycle pulse when a frame completes

module spi_stream_tx #(
   parameter int          NUM_CH      = 2,
   parameter int          WIDTH       = 16,
   parameter int          DIVISOR     = 200,
   parameter int          CS_GAP      = 2,
   parameter bit          CPOL        = 1'b0,
   parameter logic [31:0] START_VALUE = 32'd0,
   parameter logic [31:0] STEP        = 32'd1
) (
   input  logic              CLK_IN,
   input  logic              RST_N,
   input  logic [NUM_CH-1:0] enable,
   output logic [NUM_CH-1:0] CS,
   output logic [NUM_CH-1:0] SCLK,
   output logic [NUM_CH-1:0] SDO,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] frame_done
);

   localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int BIT_W = $clog2(WIDTH);
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIVISOR - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);
   localparam logic [WIDTH-1:0] WORD_INIT = START_VALUE[WIDTH-1:0];
   localparam logic [WIDTH-1:0] WORD_STEP = STEP[WIDTH-1:0];

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // Shared tick: down-counter that reloads on the cycle it reads zero.
   // With DIVISOR=1 the counter is always zero and tick is constant high.
   // ---------------------------------------------------------------
   logic [DIV_W-1:0] div_cnt_reg;
   logic             tick;

   assign tick = (div_cnt_reg == '0);

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         div_cnt_reg <= DIV_LAST;
      end else if (tick) begin
         div_cnt_reg <= DIV_LAST;
      end else begin
         div_cnt_reg <= div_cnt_reg - DIV_W'(1);
      end
   end

   // ---------------------------------------------------------------
   // Per-channel serialiser
   // ---------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic             cs_reg, cs_next;
      logic             sclk_reg, sclk_next;
      logic             sdo_reg, sdo_next;
      logic             done_reg, done_next;
      logic [WIDTH-1:0] word_reg, word_next;
      logic [WIDTH-1:0] shift_reg, shift_next;
      logic [BIT_W-1:0] bit_reg, bit_next;
      logic [GAP_W-1:0] gap_reg, gap_next;

      always_ff @(posedge CLK_IN or negedge RST_N) begin
         if (!RST_N) begin
            state_reg <= ST_IDLE;
            cs_reg    <= 1'b1;
            sclk_reg  <= CPOL;
            sdo_reg   <= 1'b0;
            done_reg  <= 1'b0;
            word_reg  <= WORD_INIT;
            shift_reg <= '0;
            bit_reg   <= '0;
            gap_reg   <= '0;
         end else begin
            state_reg <= state_next;
            cs_reg    <= cs_next;
            sclk_reg  <= sclk_next;
            sdo_reg   <= sdo_next;
            done_reg  <= done_next;
            word_reg  <= word_next;
            shift_reg <= shift_next;
            bit_reg   <= bit_next;
            gap_reg   <= gap_next;
         end
      end

      always_comb begin
         state_next = state_reg;
         cs_next    = cs_reg;
         sclk_next  = sclk_reg;
         sdo_next   = sdo_reg;
         done_next  = 1'b0;            // frame_done is a single-cycle pulse
         word_next  = word_reg;
         shift_next = shift_reg;
         bit_next   = bit_reg;
         gap_next   = gap_reg;

         if (tick) begin
            case (state_reg)
               ST_IDLE: begin
                  if (enable[gi]) begin
                     state_next = ST_SHIFT;
                     cs_next    = 1'b0;
                     sclk_next  = CPOL;
                     shift_next = word_reg;
                     sdo_next   = word_reg[WIDTH-1];
                     bit_next   = BIT_LAST;
                  end
               end

               ST_SHIFT: begin
                  if (sclk_reg == CPOL) begin
                     // leading edge: receiver samples, data holds
                     sclk_next = ~CPOL;
                  end else if (bit_reg != '0) begin
                     // trailing edge: present the next bit
                     sclk_next  = CPOL;
                     shift_next = {shift_reg[WIDTH-2:0], 1'b0};
                     sdo_next   = shift_reg[WIDTH-2];
                     bit_next   = bit_reg - BIT_W'(1);
                  end else begin
                     // last trailing edge closes the frame
                     state_next = ST_GAP;
                     sclk_next  = CPOL;
                     cs_next    = 1'b1;
                     sdo_next   = 1'b0;
                     done_next  = 1'b1;
                     word_next  = word_reg + WORD_STEP;
                     gap_next   = GAP_LAST;
                  end
               end

               ST_GAP: begin
                  if (gap_reg != '0) begin
                     gap_next = gap_reg - GAP_W'(1);
                  end else if (enable[gi]) begin
                     // back-to-back frame: CS drops on the gap's last tick
                     state_next = ST_SHIFT;
                     cs_next    = 1'b0;
                     sclk_next  = CPOL;
                     shift_next = word_reg;
                     sdo_next   = word_reg[WIDTH-1];
                     bit_next   = BIT_LAST;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end

               default: begin
                  state_next = ST_IDLE;
                  cs_next    = 1'b1;
                  sclk_next  = CPOL;
                  sdo_next   = 1'b0;
               end
            endcase
         end
      end

      assign CS[gi]         = cs_reg;
      assign SCLK[gi]       = sclk_reg;
      assign SDO[gi]        = sdo_reg;
      assign busy[gi]       = (state_reg != ST_IDLE);
      assign frame_done[gi] = done_reg;
   end

endmodule

// File: tb/tb_spi_stream_tx.sv
// tb_spi_stream_tx
//   Directed bench for spi_stream_tx. Instance dut_a uses CPOL=0 and start
//   word A5; instance dut_b uses CPOL=1 and start word FF. Both use WIDTH=8,
//   DIVISOR=4, CS_GAP=2, STEP=1. Expected values are hand-computed constants.
//   Outputs are sampled on the falling clock edge; inputs change there too.

module tb_spi_stream_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] en_a, en_b;
   logic [1:0] cs_a, sclk_a, sdo_a, busy_a, fd_a;
   logic [1:0] cs_b, sclk_b, sdo_b, busy_b, fd_b;

   int n_cmp = 0;
   int n_bad = 0;
   int ch1_low = 0;

   always #5 clk = ~clk;

   spi_stream_tx #(
      .NUM_CH(2), .WIDTH(8), .DIVISOR(4), .CS_GAP(2), .CPOL(1'b0),
      .START_VALUE(32'h0000_00A5), .STEP(32'd1)
   ) dut_a (
      .CLK_IN(clk), .RST_N(rst_n), .enable(en_a), .CS(cs_a), .SCLK(sclk_a),
      .SDO(sdo_a), .busy(busy_a), .frame_done(fd_a)
   );

   spi_stream_tx #(
      .NUM_CH(2), .WIDTH(8), .DIVISOR(4), .CS_GAP(2), .CPOL(1'b1),
      .START_VALUE(32'h0000_00FF), .STEP(32'd1)
   ) dut_b (
      .CLK_IN(clk), .RST_N(rst_n), .enable(en_b), .CS(cs_b), .SCLK(sclk_b),
      .SDO(sdo_b), .busy(busy_b), .frame_done(fd_b)
   );

   always @(negedge clk) begin
      if (!cs_a[1]) ch1_low++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   function automatic logic s_cs(input bit inst, input bit ch);
      return inst ? cs_b[ch] : cs_a[ch];
   endfunction
   function automatic logic s_sclk(input bit inst, input bit ch);
      return inst ? sclk_b[ch] : sclk_a[ch];
   endfunction
   function automatic logic s_sdo(input bit inst, input bit ch);
      return inst ? sdo_b[ch] : sdo_a[ch];
   endfunction
   function automatic logic s_fd(input bit inst, input bit ch);
      return inst ? fd_b[ch] : fd_a[ch];
   endfunction

   // Waits (bounded) for CS low, then records one frame up to and including
   // the first sample with CS high again. Leading edge is the transition away
   // from the instance's idle level (dut_b idles high).
   task automatic capture(input bit inst, input bit ch, output logic [7:0] word,
                          output int low_len, output int edges, output int fd_cnt,
                          output int unstable);
      logic idle, prev_sclk, prev_sdo, cur_sclk, cur_sdo;
      int   guard;
      idle     = inst;
      word     = '0;
      low_len  = 0;
      edges    = 0;
      fd_cnt   = 0;
      unstable = 0;
      guard    = 0;
      while (s_cs(inst, ch) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!s_cs(inst, ch)) begin
         low_len   = 1;
         prev_sclk = s_sclk(inst, ch);
         prev_sdo  = s_sdo(inst, ch);
         fd_cnt    = int'(s_fd(inst, ch));
         guard     = 0;
         while (guard < 300) begin
            @(negedge clk);
            guard++;
            fd_cnt += int'(s_fd(inst, ch));
            if (s_cs(inst, ch)) break;
            low_len++;
            cur_sclk = s_sclk(inst, ch);
            cur_sdo  = s_sdo(inst, ch);
            if (prev_sclk == idle && cur_sclk != idle) begin
               edges++;
               word = {word[6:0], cur_sdo};
               if (cur_sdo != prev_sdo) unstable++;
            end
            prev_sclk = cur_sclk;
            prev_sdo  = cur_sdo;
         end
      end
   endtask

   // Counts CS-high samples, starting with the current one, until CS falls.
   task automatic measure_gap(input bit inst, input bit ch, output int gap);
      gap = 1;
      while (gap < 100) begin
         @(negedge clk);
         if (!s_cs(inst, ch)) break;
         gap++;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [7:0] w;
   int         len, edg, fdc, uns, gap, lat, snap;
   logic [7:0] exp_words [3] = '{8'hA5, 8'hA6, 8'hA7};

   initial begin
      rst_n = 1'b0;
      en_a  = 2'b11;
      en_b  = 2'b00;
      repeat (3) @(negedge clk);

      // reset values
      check("rst_cs", 32'(cs_a), 32'h3);
      check("rst_sclk", 32'(sclk_a), 32'h0);
      check("rst_sdo", 32'(sdo_a), 32'h0);
      check("rst_busy", 32'(busy_a), 32'h0);
      check("rst_done", 32'(fd_a), 32'h0);
      check("rst_sclk_cpol1", 32'(sclk_b), 32'h3);

      // release: first tick on the 4th edge, both channels start together
      rst_n = 1'b1;
      lat   = 0;
      while (cs_a[0] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("start_latency", 32'(lat), 32'd4);
      check("simul_start", 32'(cs_a), 32'h0);
      en_a = 2'b00;
      capture(1'b0, 1'b0, w, len, edg, fdc, uns);
      check("t1_word", 32'(w), 32'hA5);
      check("t1_cs_low", 32'(len), 32'd64);
      check("simul_end_cs", 32'(cs_a), 32'h3);
      check("simul_end_done", 32'(fd_a), 32'h3);
      check("t1_busy_gap", 32'(busy_a), 32'h3);
      repeat (12) @(negedge clk);
      check("t1_idle", 32'(busy_a), 32'h0);

      // single frame from an 8-cycle enable pulse
      pulse_reset();
      snap = ch1_low;
      fork
         begin
            en_a[0] = 1'b1;
            repeat (8) @(negedge clk);
            en_a[0] = 1'b0;
         end
         capture(1'b0, 1'b0, w, len, edg, fdc, uns);
      join
      check("single_word", 32'(w), 32'hA5);
      check("single_cs_low", 32'(len), 32'd64);
      check("single_edges", 32'(edg), 32'd8);
      check("single_done", 32'(fdc), 32'd1);
      check("single_stable", 32'(uns), 32'd0);
      check("single_ch1_quiet", 32'(ch1_low - snap), 32'd0);
      repeat (12) @(negedge clk);
      check("single_idle", 32'(busy_a), 32'h0);

      // continuous run; enable dropped mid-way through the third frame
      pulse_reset();
      en_a[0] = 1'b1;
      for (int f = 0; f < 3; f++) begin
         if (f == 2) begin
            fork
               begin
                  repeat (20) @(negedge clk);
                  en_a[0] = 1'b0;
               end
               capture(1'b0, 1'b0, w, len, edg, fdc, uns);
            join
         end else begin
            capture(1'b0, 1'b0, w, len, edg, fdc, uns);
         end
         check($sformatf("cont_word%0d", f), 32'(w), 32'(exp_words[f]));
         check($sformatf("cont_cs_low%0d", f), 32'(len), 32'd64);
         check($sformatf("cont_done%0d", f), 32'(fdc), 32'd1);
         check($sformatf("cont_busy_gap%0d", f), 32'(busy_a[0]), 32'd1);
         if (f < 2) begin
            measure_gap(1'b0, 1'b0, gap);
            check($sformatf("cont_gap%0d", f), 32'(gap), 32'd8);
            check($sformatf("cont_period%0d", f), 32'(len + gap), 32'd72);
         end
      end
      repeat (12) @(negedge clk);
      check("early_drop_idle", 32'(busy_a[0]), 32'd0);
      check("early_drop_cs", 32'(cs_a[0]), 32'd1);

      // reset in the middle of a frame
      en_a[0] = 1'b1;
      lat = 0;
      while (cs_a[0] && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      repeat (30) @(negedge clk);
      check("mid_busy_before", 32'(busy_a[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_cs", 32'(cs_a), 32'h3);
      check("mid_rst_sclk", 32'(sclk_a), 32'h0);
      check("mid_rst_sdo", 32'(sdo_a), 32'h0);
      check("mid_rst_busy", 32'(busy_a), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      fork
         begin
            repeat (10) @(negedge clk);
            en_a[0] = 1'b0;
         end
         capture(1'b0, 1'b0, w, len, edg, fdc, uns);
      join
      check("after_rst_word", 32'(w), 32'hA5);
      check("after_rst_cs_low", 32'(len), 32'd64);
      repeat (12) @(negedge clk);

      // CPOL=1 instance: word wraps FF -> 00
      check("cpol1_idle_sclk", 32'(sclk_b), 32'h3);
      en_b[0] = 1'b1;
      capture(1'b1, 1'b0, w, len, edg, fdc, uns);
      check("wrap_word0", 32'(w), 32'hFF);
      check("wrap_cs_low0", 32'(len), 32'd64);
      check("wrap_edges0", 32'(edg), 32'd8);
      check("wrap_stable0", 32'(uns), 32'd0);
      check("wrap_idle_high", 32'(sclk_b[0]), 32'd1);
      measure_gap(1'b1, 1'b0, gap);
      check("wrap_gap", 32'(gap), 32'd8);
      fork
         begin
            repeat (10) @(negedge clk);
            en_b[0] = 1'b0;
         end
         capture(1'b1, 1'b0, w, len, edg, fdc, uns);
      join
      check("wrap_word1", 32'(w), 32'h00);
      check("wrap_cs_low1", 32'(len), 32'd64);
      check("wrap_done1", 32'(fdc), 32'd1);
      repeat (12) @(negedge clk);
      check("wrap_idle", 32'(busy_b), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of run");
      $fatal(1, "watchdog expired");
   end

endmodule
